// File: rtl/reg_dump_uart_tx.sv
// Register file dump over UART: walks indices 0..REG_NUM-1 and sends each
// 32-bit word as four 8N1 frames, most significant byte first.
module reg_dump_uart_tx #(
  parameter int REG_NUM     = 32,
  parameter int CLK_PER_BIT = 868,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    TX,
    DONE
  } state_t;

  state_t            state;
  logic [31:0]       word;
  logic [1:0]        byte_cnt;
  logic [3:0]        bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [7:0]        cur_byte;
  logic              next_bit;

  always_comb begin
    cur_byte = word[31:24];
    case (byte_cnt)
      2'd0: cur_byte = word[31:24];
      2'd1: cur_byte = word[23:16];
      2'd2: cur_byte = word[15:8];
      2'd3: cur_byte = word[7:0];
      default: cur_byte = word[31:24];
    endcase
  end

  // Value of the slot that follows the current one: bit_cnt 0..7 leads into
  // data bit bit_cnt, bit_cnt 8 leads into the stop bit.
  always_comb begin
    next_bit = 1'b1;
    if (bit_cnt < 4'd8) next_bit = cur_byte[bit_cnt[2:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      word     <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      rd_addr  <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          txd     <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
          rd_addr <= '0;
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end

        LOAD: begin
          word     <= rd_data;
          byte_cnt <= '0;
          bit_cnt  <= '0;
          baud_cnt <= '0;
          txd      <= 1'b0;
          state    <= TX;
        end

        TX: begin
          if (baud_cnt == BAUD_W'(CLK_PER_BIT - 1)) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              bit_cnt <= '0;
              if (byte_cnt == 2'd3) begin
                byte_cnt <= '0;
                txd      <= 1'b1;
                if (rd_addr == ADDR_W'(REG_NUM - 1)) begin
                  done  <= 1'b1;
                  state <= DONE;
                end else begin
                  rd_addr <= rd_addr + ADDR_W'(1);
                  state   <= LOAD;
                end
              end else begin
                byte_cnt <= byte_cnt + 2'd1;
                txd      <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              txd     <= next_bit;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          txd     <= 1'b1;
          rd_addr <= '0;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Directed bench for reg_dump_uart_tx with REG_NUM=4, CLK_PER_BIT=4.
module tb_reg_dump_uart_tx;

  localparam int NREG = 4;
  localparam int CPB  = 4;
  localparam int AW   = 2;
  localparam int REGC = 1 + 40 * CPB;  // cycles per register
  localparam int LOGN = 700;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          txd;
  logic          busy;
  logic          done;

  logic [31:0] regs [0:NREG-1];
  assign rd_data = regs[rd_addr];

  reg_dump_uart_tx #(
    .REG_NUM(NREG),
    .CLK_PER_BIT(CPB),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .txd(txd),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic          tx_log   [0:LOGN-1];
  logic          busy_log [0:LOGN-1];
  logic          done_log [0:LOGN-1];
  logic [AW-1:0] addr_log [0:LOGN-1];
  logic          start_plan [0:LOGN-1];
  logic          wr_en  [0:LOGN-1];
  int            wr_idx [0:LOGN-1];
  logic [31:0]   wr_val [0:LOGN-1];
  logic [31:0]   exp_w  [0:NREG-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < LOGN; i++) begin
      start_plan[i] = 1'b0;
      wr_en[i]      = 1'b0;
      wr_idx[i]     = 0;
      wr_val[i]     = '0;
    end
  endtask

  // Cycle 0 is the LOAD cycle following the edge that accepted start.
  task automatic record(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      tx_log[c]   = txd;
      busy_log[c] = busy;
      done_log[c] = done;
      addr_log[c] = rd_addr;
      start = start_plan[c];
      if (wr_en[c]) regs[wr_idx[c]] = wr_val[c];
      if (c < ncyc - 1) tick();
    end
  endtask

  // Checks one frame starting at cycle f: every cycle of every slot, and the decoded byte.
  task automatic check_frame(input string nm, input int f, input logic [7:0] expb);
    int          errs;
    logic        want;
    logic [7:0]  got;
    errs = 0;
    for (int s = 0; s < 10; s++) begin
      if (s == 0)      want = 1'b0;
      else if (s == 9) want = 1'b1;
      else             want = expb[s-1];
      for (int t = 0; t < CPB; t++)
        if (tx_log[f + s*CPB + t] !== want) errs++;
    end
    for (int i = 0; i < 8; i++) got[i] = tx_log[f + (i+1)*CPB + CPB/2];
    check($sformatf("%s_byte", nm), {24'd0, got}, {24'd0, expb});
    check($sformatf("%s_slots", nm), errs, 0);
  endtask

  task automatic check_dump(input string nm, input int base);
    logic [7:0] b;
    for (int k = 0; k < NREG; k++)
      for (int j = 0; j < 4; j++) begin
        b = exp_w[k][31 - 8*j -: 8];
        check_frame($sformatf("%s_r%0d_b%0d", nm, k, j), base + k*REGC + 1 + 40*j, b);
      end
    for (int k = 1; k < NREG; k++) begin
      check($sformatf("%s_load_txd%0d", nm, k), tx_log[base + k*REGC], 1'b1);
      check($sformatf("%s_load_addr%0d", nm, k), addr_log[base + k*REGC], k);
    end
  endtask

  logic [9:0] shape;
  int         nbad;
  int         ndone;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    regs[0] = 32'h12345678;
    regs[1] = 32'hDEADBEEF;
    regs[2] = 32'h00000000;
    regs[3] = 32'hFFFFFFFF;
    #1;
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_addr", rd_addr, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("idle_txd", txd, 1'b1);
    check("idle_busy", busy, 1'b0);

    // Dump 1: plain data, with start pulses at 10, 300 and 644 to be ignored.
    clear_plan();
    start_plan[10]  = 1'b1;
    start_plan[300] = 1'b1;
    start_plan[644] = 1'b1;
    start = 1'b1;
    tick();
    record(LOGN);
    start = 1'b0;
    check("d1_c0_busy", busy_log[0], 1'b1);
    check("d1_c0_txd", tx_log[0], 1'b1);
    check("d1_c0_addr", addr_log[0], 0);
    shape = 10'b1000100100;
    for (int c = 1; c <= 40; c++)
      check($sformatf("d1_shape_c%0d", c), tx_log[c], shape[(c-1)/CPB]);
    exp_w[0] = 32'h12345678;
    exp_w[1] = 32'hDEADBEEF;
    exp_w[2] = 32'h00000000;
    exp_w[3] = 32'hFFFFFFFF;
    check_dump("d1", 0);
    ndone = 0;
    nbad  = 0;
    for (int c = 0; c < LOGN; c++) begin
      if (done_log[c] === 1'b1) ndone++;
      if (c <= 644 && busy_log[c] !== 1'b1) nbad++;
      if (c >= 645 && (busy_log[c] !== 1'b0 || tx_log[c] !== 1'b1)) nbad++;
    end
    check("d1_done_644", done_log[644], 1'b1);
    check("d1_done_count", ndone, 1);
    check("d1_busy_window", nbad, 0);
    check("d1_addr_after", addr_log[645], 0);

    // Dump 2: start held high; writes to r0 (after capture) and r1 (before its LOAD).
    clear_plan();
    for (int c = 0; c < LOGN; c++) start_plan[c] = 1'b1;
    wr_en[5]  = 1'b1; wr_idx[5]  = 0; wr_val[5]  = 32'h00000000;
    wr_en[50] = 1'b1; wr_idx[50] = 1; wr_val[50] = 32'hAAAAAAAA;
    start = 1'b1;
    tick();
    record(697);
    exp_w[0] = 32'h12345678;
    exp_w[1] = 32'hAAAAAAAA;
    exp_w[2] = 32'h00000000;
    exp_w[3] = 32'hFFFFFFFF;
    check_dump("d2", 0);
    check("d2_done_644", done_log[644], 1'b1);
    check("d2_done_643", done_log[643], 1'b0);
    check("d2_busy_644", busy_log[644], 1'b1);
    check("b2b_gap_busy", busy_log[645], 1'b0);
    check("b2b_gap_txd", tx_log[645], 1'b1);
    check("b2b_gap_done", done_log[645], 1'b0);
    check("b2b_load_busy", busy_log[646], 1'b1);
    check("b2b_load_txd", tx_log[646], 1'b1);
    check("b2b_load_addr", addr_log[646], 0);
    check("b2b_start_bit", tx_log[647], 1'b0);
    check_frame("b2b_r0_b0", 647, 8'h00);

    // Asynchronous reset in cycle 50 of the third dump (mid byte 1).
    check("pre_rst_busy", busy, 1'b1);
    start = 1'b0;
    reset = 1'b1;
    #1;
    check("arst_txd", txd, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_addr", rd_addr, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_txd", txd, 1'b1);

    // Dump 4: complete dump from r0 after reset.
    regs[0] = 32'h12345678;
    clear_plan();
    start = 1'b1;
    tick();
    record(646);
    exp_w[0] = 32'h12345678;
    exp_w[1] = 32'hAAAAAAAA;
    exp_w[2] = 32'h00000000;
    exp_w[3] = 32'hFFFFFFFF;
    check_dump("d4", 0);
    check("d4_c0_addr", addr_log[0], 0);
    check("d4_done_644", done_log[644], 1'b1);
    check("d4_busy_645", busy_log[645], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_dump_uart_tx.md
# reg_dump_uart_tx

Read-side counterpart to the CPU register file's UART write path. On a start pulse it walks the register file from index 0 to REG_NUM-1 through a dedicated read port. Each 32-bit word is serialized onto a UART TX line as four 8N1 frames, most significant byte first. It serves as the host-visible state dump after a program halts, and it sits beside the register file and the UART loader in the core.

## Interface

Parameters:
- REG_NUM, 32, number of registers dumped (indices 0..REG_NUM-1); REG_NUM >= 1
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); CLK_PER_BIT >= 2
- ADDR_W, 5, width of rd_addr; must satisfy 2**ADDR_W >= REG_NUM

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a dump; sampled only in IDLE
- rd_addr  output  ADDR_W  register file read index
- rd_data  input  32  register file read data; combinational from rd_addr, valid in the same cycle
- txd  output  1  UART serial output; idles high
- busy  output  1  high from the cycle after start is accepted through the DONE cycle
- done  output  1  one-cycle pulse when the last register's last stop bit has finished

## Operation

- States: IDLE, LOAD, TX, DONE.
- IDLE:
  - txd=1, busy=0, rd_addr holds 0.
  - start=1 at an edge moves to LOAD with index=0.
- LOAD (one cycle):
  - rd_addr=index.
  - At the next edge, rd_data is captured into a 32-bit word register, byte_cnt=0, bit_cnt=0, baud_cnt=0, and the state moves to TX.
- TX:
  - Each byte is sent as one frame: start bit (0), data bits 0..7 LSB first, stop bit (1). That is 10 bit slots.
  - Byte order: byte_cnt 0 sends word[31:24], 1 sends word[23:16], 2 sends word[15:8], 3 sends word[7:0].
  - baud_cnt counts 0..CLK_PER_BIT-1. Each slot lasts exactly CLK_PER_BIT cycles.
  - Bytes within a word are back-to-back, with no idle gap after a stop bit.
  - After byte 3's stop bit:
    - if index == REG_NUM-1, go to DONE;
    - otherwise index+1, go to LOAD. The LOAD cycle drives txd=1, which extends that stop bit by one cycle.
- DONE (one cycle): done=1, busy=1, txd=1, then IDLE.
- start while busy is ignored. It is not queued.
- rd_addr changes only on entry to LOAD and returns to 0 in IDLE.
- txd is registered, so it is glitch-free.

## Timing

- Reset values: txd=1, busy=0, done=0, rd_addr=0; state=IDLE; all counters 0.
- Reset asserted mid-frame:
  - txd goes to 1 immediately (asynchronous) and the dump is abandoned.
  - After release, the block waits in IDLE for a new start.
- Edge 0 samples start:
  - cycle 0 is LOAD (busy=1);
  - the start bit of byte 0 begins in cycle 1.
- Per register: 1 + 40*CLK_PER_BIT cycles.
- Register k's LOAD occurs in cycle k*(1+40*CLK_PER_BIT).
- done is high in cycle REG_NUM*(1+40*CLK_PER_BIT) only. busy drops in the following cycle.
- A start high in the same cycle as DONE is ignored. A start high in the first IDLE cycle after DONE is accepted.
- rd_data must be stable during the LOAD cycle only. Register writes during TX do not affect the word already in flight.

## Test plan

- Single dump, REG_NUM=4, CLK_PER_BIT=4, r[0..3]=0x12345678, 0xDEADBEEF, 0x00000000, 0xFFFFFFFF -> a UART monitor decodes bytes 12 34 56 78 DE AD BE EF 00 00 00 00 FF FF FF FF; every bit is exactly 4 cycles; done is high only in cycle 644.
- Frame shape: first byte 0x12, CLK_PER_BIT=4 -> txd is 0 for cycles 1-4, then 0,1,0,0,1,0,0,0 in 4-cycle slots, then 1 for the stop bit.
- start pulsed again in cycles 10, 300 and 644 -> ignored; exactly one dump; busy is never deasserted early.
- Write r[1] to 0xAAAAAAAA during the transmission of r[0] (before r[1]'s LOAD) -> bytes AA AA AA AA are sent for r[1]. A write to r[0] after cycle 0 does not change r[0]'s bytes.
- Reset asserted in cycle 50 (mid byte 1) -> txd=1, busy=0 asynchronously. A new start after release produces a complete dump from r[0].
- Back-to-back dumps: start held high continuously -> the second dump's LOAD is in cycle 646, with a one-cycle IDLE gap and a txd=1 gap between dumps.
